// File: rtl/spi_resp_if.sv
// -----------------------------------------------------------------------------
// spi_resp_if
// Core-side response handshake for the SPI-slave transmit path.
//   data_in   : response word from the core
//   valid_in  : data_in valid
//   ready_out : serializer holding register empty; a word is accepted on
//               any clk edge where valid_in && ready_out
// Modports: master = core side (drives data/valid), slave = serializer side.
// -----------------------------------------------------------------------------
interface spi_resp_if #(
    parameter int DATAW = 8
);
    logic [DATAW-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/spi_resp_serializer.sv
// -----------------------------------------------------------------------------
// spi_resp_serializer
// SPI-slave transmit path, mode 0 (CPOL=0, CPHA=0). Response words arrive from
// the core over a valid/ready handshake into a one-word holding register and
// are shifted out on MISO. spi_clk and cs_n come from the master and are
// oversampled by clk through 2-FF synchronizers.
// Ports:
//   clk, rst_n  : chip clock, asynchronous active-low reset
//   spi_clk     : SPI clock from master (async to clk)
//   cs_n        : SPI chip select, active low (async to clk)
//   core        : data_in / valid_in / ready_out handshake (slave side)
//   miso        : serial data to master (registered)
//   busy        : a word frame is active (state SHIFT)
//   tx_done     : 1-clk pulse, last bit of a word sampled by the master
//   underrun    : 1-clk pulse, word slot opened with holding register empty
//   abort       : 1-clk pulse, cs_n deasserted mid-word
// -----------------------------------------------------------------------------
module spi_resp_serializer #(
    parameter int DATAW     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       cs_n,
    spi_resp_if.slave  core,
    output logic       miso,
    output logic       busy,
    output logic       tx_done,
    output logic       underrun,
    output logic       abort
);
    localparam int              CW   = $clog2(DATAW + 1);
    localparam logic [DATAW-1:0] FILL = {DATAW{IDLE_BIT}};

    typedef enum logic {IDLE, SHIFT} state_t;

    // Bit that goes on the wire first for a freshly loaded / shifted word.
    function automatic logic first_bit(input logic [DATAW-1:0] w);
        return MSB_FIRST ? w[DATAW-1] : w[0];
    endfunction

    // Drop the bit just sent; refill the vacated end with the idle level.
    function automatic logic [DATAW-1:0] shift_out(input logic [DATAW-1:0] w);
        return MSB_FIRST ? {w[DATAW-2:0], IDLE_BIT} : {IDLE_BIT, w[DATAW-1:1]};
    endfunction

    // Synchronizer chains: [0],[1] are the 2-FF sync, [2] is the previous
    // synced value used for edge detection.
    logic [2:0]       spi_sync_q, spi_sync_d;
    logic [2:0]       cs_sync_q,  cs_sync_d;
    state_t           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             reload_q,   reload_d;
    logic [DATAW-1:0] sh_q,       sh_d;
    logic [DATAW-1:0] hold_q,     hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             miso_q,     miso_d;
    logic             tx_done_q,  tx_done_d;
    logic             underrun_q, underrun_d;
    logic             abort_q,    abort_d;

    logic spi_rise, spi_fall, cs_fall, cs_rise, load;

    assign spi_rise = spi_sync_q[1] & ~spi_sync_q[2];
    assign spi_fall = ~spi_sync_q[1] & spi_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];

    always_comb begin
        spi_sync_d   = {spi_sync_q[1:0], spi_clk};
        cs_sync_d    = {cs_sync_q[1:0], cs_n};
        state_d      = state_q;
        cnt_d        = cnt_q;
        reload_d     = reload_q;
        sh_d         = sh_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        miso_d       = miso_q;
        tx_done_d    = 1'b0;
        underrun_d   = 1'b0;
        abort_d      = 1'b0;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                // spi_clk edges are ignored until the frame opens.
                if (cs_fall) begin
                    state_d  = SHIFT;
                    load     = 1'b1;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                end
            end
            SHIFT: begin
                // cs_rise wins over a same-cycle spi edge.
                if (cs_rise) begin
                    state_d  = IDLE;
                    abort_d  = (cnt_q != '0);
                    sh_d     = FILL;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    miso_d   = IDLE_BIT;
                end else if (spi_rise) begin
                    if (cnt_q == CW'(DATAW - 1)) begin
                        // Master just sampled the last bit; next fall loads
                        // the following word within the same frame.
                        tx_done_d = 1'b1;
                        cnt_d     = '0;
                        reload_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (spi_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        sh_d   = shift_out(sh_q);
                        miso_d = first_bit(shift_out(sh_q));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (hold_valid_q) begin
                sh_d         = hold_q;
                hold_valid_d = 1'b0;
                miso_d       = first_bit(hold_q);
            end else begin
                sh_d       = FILL;
                underrun_d = 1'b1;
                miso_d     = IDLE_BIT;
            end
        end

        // Accept only into an empty hold; a word accepted in the same cycle
        // as an empty LOAD waits for the next slot.
        if (core.valid_in && !hold_valid_q) begin
            hold_d       = core.data_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_sync_q   <= 3'b000;
            cs_sync_q    <= 3'b111;
            state_q      <= IDLE;
            cnt_q        <= '0;
            reload_q     <= 1'b0;
            sh_q         <= FILL;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            miso_q       <= IDLE_BIT;
            tx_done_q    <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            spi_sync_q   <= spi_sync_d;
            cs_sync_q    <= cs_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reload_q     <= reload_d;
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            miso_q       <= miso_d;
            tx_done_q    <= tx_done_d;
            underrun_q   <= underrun_d;
            abort_q      <= abort_d;
        end
    end

    assign core.ready_out = ~hold_valid_q;
    assign miso           = miso_q;
    assign busy           = (state_q == SHIFT);
    assign tx_done        = tx_done_q;
    assign underrun       = underrun_q;
    assign abort          = abort_q;
endmodule
